// File: rtl/fork_reader.sv
// rtl/fork_reader.sv - buffered channel reader fanning words out to NUM_PORTS consumers
// Define FORK_BROADCAST_EN to deliver every word to all consumers instead of round-robin.
module fork_reader #(
  parameter int WIDTH     = 32,
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           channel_read_data,
  input  logic                       channel_read_valid,
  output logic                       channel_read_request,
  input  logic [NUM_PORTS-1:0]       p_read_request,
  output logic [NUM_PORTS-1:0]       p_read_valid,
  output logic [NUM_PORTS*WIDTH-1:0] p_read_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 not_empty;
  logic                 enq;
  logic                 deq;
  logic [NUM_PORTS-1:0] valid;
  logic [WIDTH-1:0]     head;

  // Outputs are forced idle while reset is held, even if words were buffered.
  assign not_empty            = (count_q != '0) && !reset;
  assign channel_read_request = reset || (count_q != CW'(DEPTH));
  assign enq                  = channel_read_valid && (count_q != CW'(DEPTH));
  assign head                 = not_empty ? mem_q[rd_ptr_q] : '0;
  assign p_read_data          = {NUM_PORTS{head}};
  assign p_read_valid         = valid;

`ifdef FORK_BROADCAST_EN
  logic [NUM_PORTS-1:0] delivered_q, delivered_d;

  always_comb begin
    valid       = not_empty ? (p_read_request & ~delivered_q) : '0;
    deq         = not_empty && (&(delivered_q | valid));
    delivered_d = deq ? '0 : (delivered_q | valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delivered_q <= '0;
    end else begin
      delivered_q <= delivered_d;
    end
  end
`else
  localparam int RW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [RW-1:0] rr_q, rr_d;
  logic [RW-1:0] idx;

  // Search starts at rr so the port after the last winner has priority.
  always_comb begin
    valid = '0;
    deq   = 1'b0;
    rr_d  = rr_q;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = RW'((int'(rr_q) + i) % NUM_PORTS);
      if (not_empty && !deq && p_read_request[idx]) begin
        valid[idx] = 1'b1;
        deq        = 1'b1;
        rr_d       = RW'((int'(idx) + 1) % NUM_PORTS);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= channel_read_data;
    end
  end

endmodule

// File: tb/tb_fork_reader.sv
// tb/tb_fork_reader.sv - directed self-checking bench for fork_reader
module tb_fork_reader;
  localparam int W = 32;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   crd;
  logic           crv;
  logic           crr;
  logic [N-1:0]   preq;
  logic [N-1:0]   pv;
  logic [N*W-1:0] pd;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fork_reader #(.WIDTH(W), .NUM_PORTS(N), .DEPTH(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .channel_read_data    (crd),
    .channel_read_valid   (crv),
    .channel_read_request (crr),
    .p_read_request       (preq),
    .p_read_valid         (pv),
    .p_read_data          (pd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nw;
    int rx;
    int cyc;
    logic ok;

    reset = 1'b1; crv = 1'b0; crd = '0; preq = 2'b11;
    step();
    #1;
    chk("in_rst_crr", crr, 1);
    chk("in_rst_pv", pv, 0);
    chk("in_rst_pd", pd, 0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_crr", crr, 1);
    chk("post_rst_pv", pv, 0);
    chk("post_rst_pd", pd, 0);

`ifdef FORK_BROADCAST_EN
    preq = 2'b00;
    step(); crv = 1'b1; crd = 32'h55;
    step(); crd = 32'h66;
    step(); crv = 1'b0; preq = 2'b01;
    #1;
    chk("t6_t_pv", pv, 2'b01);
    chk("t6_t_pd0", pd[31:0], 32'h55);
    step();
    #1;
    chk("t6_t1_pv", pv, 2'b00);
    step(); preq = 2'b10;
    #1;
    chk("t6_t2_pv", pv, 2'b10);
    chk("t6_t2_pd1", pd[63:32], 32'h55);
    step(); preq = 2'b11;
    #1;
    chk("t6_t3_pv", pv, 2'b11);
    chk("t6_t3_pd", pd, {32'h66, 32'h66});
    step();
`else
    // Test 1: two words, both consumers requesting
    step(); crv = 1'b1; crd = 32'hA0;
    #1;
    chk("t1_c1_pv", pv, 2'b00);
    step(); crd = 32'hA1;
    #1;
    chk("t1_c2_pv", pv, 2'b01);
    chk("t1_c2_pd0", pd[31:0], 32'hA0);
    step(); crv = 1'b0;
    #1;
    chk("t1_c3_pv", pv, 2'b10);
    chk("t1_c3_pd1", pd[63:32], 32'hA1);
    step();
    #1;
    chk("t1_c4_pv", pv, 2'b00);
    preq = 2'b00; crv = 1'b1; crd = 32'hB0;
    step(); crv = 1'b0; preq = 2'b11;
    #1;
    chk("t1_rr0_pv", pv, 2'b01);
    chk("t1_rr0_pd0", pd[31:0], 32'hB0);
    step(); preq = 2'b00;

    // Test 2: fill without consumers, then drain to consumer 0
    nw = 1;
    for (int c = 1; c <= 5; c++) begin
      crd = nw; crv = 1'b1;
      #1;
      chk("t2_crr", crr, (c < 5) ? 1 : 0);
      ok = crr;
      step();
      if (ok) nw++;
    end
    chk("t2_accepted", nw - 1, 4);
    preq = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      crd = nw; crv = (nw <= 6);
      #1;
      chk("t2_pv", pv, 2'b01);
      chk("t2_pd0", pd[31:0], k);
      ok = crv && crr;
      step();
      if (ok) nw++;
    end
    crv = 1'b0;
    #1;
    chk("t2_empty_pv", pv, 2'b00);
    preq = 2'b00;

    // Test 5: reset with three words buffered
    for (int k = 0; k < 3; k++) begin
      crv = 1'b1; crd = 32'h30 + k;
      step();
    end
    crv = 1'b0; preq = 2'b11; reset = 1'b1;
    #1;
    chk("t5_rst_pv", pv, 2'b00);
    step(); reset = 1'b0; crv = 1'b1; crd = 32'h40; preq = 2'b10;
    #1;
    chk("t5_after_pv", pv, 2'b00);
    chk("t5_after_crr", crr, 1);
    step(); crv = 1'b0;
    #1;
    chk("t5_first_pv", pv, 2'b10);
    chk("t5_first_pd1", pd[63:32], 32'h40);
    step(); preq = 2'b00;

    // Test 3: only consumer 1 requesting, rr = 0
    for (int k = 0; k < 3; k++) begin
      crv = 1'b1; crd = 32'h50 + k;
      step();
    end
    crv = 1'b0; preq = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_pv", pv, 2'b10);
      chk("t3_pd1", pd[63:32], 32'h50 + k);
      step();
    end
    #1;
    chk("t3_empty_pv", pv, 2'b00);
    preq = 2'b00;

    // Test 4: full FIFO, one consumer, continuous upstream
    nw = 32'h10;
    for (int k = 0; k < 4; k++) begin
      crv = 1'b1; crd = nw;
      step();
      nw++;
    end
    preq = 2'b01; rx = 0; cyc = 0;
    while (rx < 16 && cyc < 60) begin
      crd = nw; crv = (nw <= 32'h1F);
      #1;
      if (pv[0]) begin
        chk("t4_sb", pd[31:0], 32'h10 + rx);
        rx++;
      end
      ok = crv && crr;
      step();
      if (ok) nw++;
      cyc++;
    end
    chk("t4_received", rx, 16);
    crv = 1'b0; preq = 2'b00;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
